// File: rtl/icmp_pkg.sv
// rtl/icmp_pkg.sv - ICMP codec state encoding, type constants and one's-complement adder
package icmp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_FOLD,
    ST_EMIT,
    ST_DONE
  } state_e;

  localparam logic [7:0] ICMP_ECHO_REPLY   = 8'd0;
  localparam logic [7:0] ICMP_ECHO_REQUEST = 8'd8;

  // 16-bit one's-complement add: the carry out wraps back into bit 0.
  function automatic logic [15:0] ones_add(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[15:0] + {15'd0, s[16]};
  endfunction

endpackage

// File: rtl/icmp_csum_acc.sv
// rtl/icmp_csum_acc.sv - Running ICMP checksum: clear, preload, or add both halves of a 32-bit word
module icmp_csum_acc
  import icmp_pkg::*;
(
  input  logic        clock,
  input  logic        hardreset,
  input  logic        clear_i,
  input  logic        load_i,
  input  logic [15:0] load_val_i,
  input  logic        add_i,
  input  logic [31:0] word_i,
  output logic [15:0] sum_o
);

  logic [15:0] sum_q, sum_d;

  always_comb begin
    sum_d = sum_q;
    if (clear_i) begin
      sum_d = '0;
    end else if (load_i) begin
      sum_d = load_val_i;
    end else if (add_i) begin
      sum_d = ones_add(ones_add(sum_q, word_i[31:16]), word_i[15:0]);
    end
  end

  always_ff @(posedge clock) begin
    if (hardreset) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign sum_o = sum_q;

endmodule

// File: rtl/icmp_codec.sv
// rtl/icmp_codec.sv - ICMP message builder/parser with checksum; ICMP_STATS_EN adds tx/rx/bad counters
module icmp_codec
  import icmp_pkg::*;
#(
  parameter int MAX_WORDS = 16,
  parameter int LEN_W     = $clog2(MAX_WORDS + 1)
) (
  input  logic             clock,
  input  logic             hardreset,
  input  logic             start,
  input  logic             mode,
  input  logic [7:0]       typeoficmpin,
  input  logic [7:0]       codein,
  input  logic [31:0]      restofheaderin,
  input  logic [LEN_W-1:0] payload_len,
  input  logic [31:0]      inputdata,
  input  logic             inputvalid,
  output logic             inputready,
  output logic [31:0]      outputmessage,
  output logic             outputvalid,
  input  logic             outputready,
  output logic             outputlast,
  output logic [7:0]       typeoficmpout,
  output logic [7:0]       codeout,
  output logic [31:0]      restofheaderout,
  output logic             checksum_ok,
  output logic             done,
  output logic             busy
`ifdef ICMP_STATS_EN
  ,
  output logic [15:0]      tx_count,
  output logic [15:0]      rx_count,
  output logic [15:0]      bad_count
`endif
);

  localparam int CNT_W = $clog2(MAX_WORDS + 3);
  localparam int AW    = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;

  state_e            state_q, state_d;
  logic              mode_q;
  logic [CNT_W-1:0]  len_q, cnt_q, cnt_d;
  logic [15:0]       hdr_q;
  logic [31:0]       rest_q;
  logic [15:0]       csum_q;
  logic [7:0]        type_out_q, code_out_q;
  logic [31:0]       rest_out_q;
  logic              ok_q;
  logic [31:0]       buf_q [MAX_WORDS];

  logic [CNT_W-1:0]  len_sat, need_words, emit_total;
  logic [AW-1:0]     wr_pos, rd_pos;
  logic              in_fire, out_fire, emit_last;
  logic              acc_load, acc_clear;
  logic [15:0]       acc_init, sum;

  assign len_sat    = (payload_len > LEN_W'(MAX_WORDS)) ? CNT_W'(MAX_WORDS) : CNT_W'(payload_len);
  assign need_words = mode_q ? len_q + CNT_W'(2) : len_q;
  assign emit_total = mode_q ? len_q : len_q + CNT_W'(2);
  assign emit_last  = (cnt_q == emit_total - CNT_W'(1));

  // Receive traffic carries two header words ahead of the payload; send output puts them in front.
  assign wr_pos = AW'(mode_q ? cnt_q - CNT_W'(2) : cnt_q);
  assign rd_pos = AW'(mode_q ? cnt_q : cnt_q - CNT_W'(2));

  assign inputready  = (state_q == ST_LOAD) && (cnt_q < need_words);
  assign in_fire     = inputready && inputvalid;
  assign outputvalid = (state_q == ST_EMIT);
  assign out_fire    = outputvalid && outputready;
  assign outputlast  = outputvalid && emit_last;
  assign done        = (state_q == ST_DONE);
  assign busy        = (state_q != ST_IDLE);

  assign acc_init  = mode ? 16'h0000
                          : ones_add(ones_add({typeoficmpin, codein}, restofheaderin[31:16]),
                                     restofheaderin[15:0]);
  assign acc_load  = (state_q == ST_IDLE) && start;
  assign acc_clear = (state_q == ST_DONE);

  icmp_csum_acc u_acc (
    .clock      (clock),
    .hardreset  (hardreset),
    .clear_i    (acc_clear),
    .load_i     (acc_load),
    .load_val_i (acc_init),
    .add_i      (in_fire),
    .word_i     (inputdata),
    .sum_o      (sum)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_LOAD;
          cnt_d   = '0;
        end
      end
      ST_LOAD: begin
        if (in_fire) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q + CNT_W'(1) == need_words) state_d = ST_FOLD;
        end else if (need_words == '0) begin
          state_d = ST_FOLD;
        end
      end
      ST_FOLD: begin
        cnt_d   = '0;
        state_d = (mode_q && len_q == '0) ? ST_DONE : ST_EMIT;
      end
      ST_EMIT: begin
        if (out_fire) begin
          if (emit_last) state_d = ST_DONE;
          else           cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    outputmessage = '0;
    if (state_q == ST_EMIT) begin
      if (mode_q)                outputmessage = buf_q[rd_pos];
      else if (cnt_q == '0)      outputmessage = {hdr_q, csum_q};
      else if (cnt_q == CNT_W'(1)) outputmessage = rest_q;
      else                       outputmessage = buf_q[rd_pos];
    end
  end

  always_ff @(posedge clock) begin
    if (in_fire && (!mode_q || cnt_q >= CNT_W'(2))) begin
      buf_q[wr_pos] <= inputdata;
    end
  end

  always_ff @(posedge clock) begin
    if (hardreset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      mode_q     <= 1'b0;
      len_q      <= '0;
      hdr_q      <= '0;
      rest_q     <= '0;
      csum_q     <= '0;
      type_out_q <= '0;
      code_out_q <= '0;
      rest_out_q <= '0;
      ok_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == ST_IDLE && start) begin
        mode_q <= mode;
        len_q  <= len_sat;
        if (!mode) begin
          hdr_q  <= {typeoficmpin, codein};
          rest_q <= restofheaderin;
        end
      end
      if (in_fire && mode_q) begin
        if (cnt_q == '0)           hdr_q  <= inputdata[31:16];
        else if (cnt_q == CNT_W'(1)) rest_q <= inputdata;
      end
      if (state_q == ST_FOLD) begin
        if (!mode_q) begin
          csum_q <= ~sum;
        end else begin
          ok_q       <= (sum == 16'hFFFF);
          type_out_q <= hdr_q[15:8];
          code_out_q <= hdr_q[7:0];
          rest_out_q <= rest_q;
        end
      end
    end
  end

  assign typeoficmpout   = type_out_q;
  assign codeout         = code_out_q;
  assign restofheaderout = rest_out_q;
  assign checksum_ok     = ok_q;

`ifdef ICMP_STATS_EN
  logic [15:0] tx_q, rx_q, bad_q;

  always_ff @(posedge clock) begin
    if (hardreset) begin
      tx_q  <= '0;
      rx_q  <= '0;
      bad_q <= '0;
    end else if (state_q == ST_DONE) begin
      if (!mode_q) begin
        if (tx_q != 16'hFFFF) tx_q <= tx_q + 16'd1;
      end else begin
        if (rx_q != 16'hFFFF) rx_q <= rx_q + 16'd1;
        if (!ok_q && bad_q != 16'hFFFF) bad_q <= bad_q + 16'd1;
      end
    end
  end

  assign tx_count  = tx_q;
  assign rx_count  = rx_q;
  assign bad_count = bad_q;
`endif

endmodule

// File: tb/tb_icmp_codec.sv
// tb/tb_icmp_codec.sv - Directed self-checking bench for icmp_codec
module tb_icmp_codec;
  import icmp_pkg::*;

  localparam int MW = 16;
  localparam int LW = $clog2(MW + 1);

  logic          clock = 1'b0;
  logic          hardreset, start, mode;
  logic [7:0]    typeoficmpin, codein;
  logic [31:0]   restofheaderin;
  logic [LW-1:0] payload_len;
  logic [31:0]   inputdata;
  logic          inputvalid, inputready;
  logic [31:0]   outputmessage;
  logic          outputvalid, outputready, outputlast;
  logic [7:0]    typeoficmpout, codeout;
  logic [31:0]   restofheaderout;
  logic          checksum_ok, done, busy;
`ifdef ICMP_STATS_EN
  logic [15:0]   tx_count, rx_count, bad_count;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] got_w[$];
  bit          got_l[$];
  int          got_done;

  always #5 clock = ~clock;

  icmp_codec #(.MAX_WORDS(MW)) dut (
    .clock(clock), .hardreset(hardreset), .start(start), .mode(mode),
    .typeoficmpin(typeoficmpin), .codein(codein), .restofheaderin(restofheaderin),
    .payload_len(payload_len), .inputdata(inputdata), .inputvalid(inputvalid),
    .inputready(inputready), .outputmessage(outputmessage), .outputvalid(outputvalid),
    .outputready(outputready), .outputlast(outputlast), .typeoficmpout(typeoficmpout),
    .codeout(codeout), .restofheaderout(restofheaderout), .checksum_ok(checksum_ok),
    .done(done), .busy(busy)
`ifdef ICMP_STATS_EN
    , .tx_count(tx_count), .rx_count(rx_count), .bad_count(bad_count)
`endif
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic begin_txn(input bit m, input logic [7:0] t, input logic [7:0] c,
                           input logic [31:0] r, input logic [LW-1:0] len);
    mode = m; typeoficmpin = t; codein = c; restofheaderin = r; payload_len = len;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic feed(input logic [31:0] w, output bit tmo);
    tmo = 1'b1;
    inputdata  = w;
    inputvalid = 1'b1;
    for (int c = 0; c < 50; c++) begin
      if (inputready) begin
        tick();
        tmo = 1'b0;
        break;
      end
      tick();
    end
    inputvalid = 1'b0;
  endtask

  task automatic collect(output bit tmo);
    got_w.delete(); got_l.delete(); got_done = 0; tmo = 1'b1;
    outputready = 1'b1;
    for (int c = 0; c < 200; c++) begin
      if (done) begin
        got_done++;
        tmo = 1'b0;
        break;
      end
      if (outputvalid && outputready) begin
        got_w.push_back(outputmessage);
        got_l.push_back(outputlast);
      end
      tick();
    end
  endtask

  task automatic test_reset();
    hardreset = 1'b1;
    tick(); tick();
    n_checks++; if ({inputready, outputvalid, outputlast, done, busy, checksum_ok} !== 6'b0)
      $display("FAIL reset_ctrl got %b want 000000", {inputready, outputvalid, outputlast, done, busy, checksum_ok}); else n_pass++;
    n_checks++; if ({typeoficmpout, codeout, restofheaderout, outputmessage} !== 80'h0)
      $display("FAIL reset_data got %h want 0", {typeoficmpout, codeout, restofheaderout, outputmessage}); else n_pass++;
    hardreset = 1'b0;
    tick();
  endtask

  task automatic test_send();
    bit tmo;
    begin_txn(1'b0, ICMP_ECHO_REQUEST, 8'd0, 32'h00010001, LW'(1));
    n_checks++; if (busy !== 1'b1) $display("FAIL send_busy got %b want 1", busy); else n_pass++;
    feed(32'h41424344, tmo);
    n_checks++; if (tmo) $display("FAIL send_feed timeout got 1 want 0"); else n_pass++;
    n_checks++; if (outputvalid !== 1'b0) $display("FAIL send_fold_valid got %b want 0", outputvalid); else n_pass++;
    tick();
    n_checks++; if (outputvalid !== 1'b1) $display("FAIL send_first_valid got %b want 1", outputvalid); else n_pass++;
    collect(tmo);
    n_checks++; if (tmo) $display("FAIL send_done timeout got 1 want 0"); else n_pass++;
    n_checks++; if (got_w.size() !== 3) $display("FAIL send_count got %0d want 3", got_w.size()); else n_pass++;
    if (got_w.size() == 3) begin
      n_checks++; if (got_w[0] !== 32'h08007377) $display("FAIL send_w0 got %h want 08007377", got_w[0]); else n_pass++;
      n_checks++; if (got_w[1] !== 32'h00010001) $display("FAIL send_w1 got %h want 00010001", got_w[1]); else n_pass++;
      n_checks++; if (got_w[2] !== 32'h41424344) $display("FAIL send_w2 got %h want 41424344", got_w[2]); else n_pass++;
      n_checks++; if ({got_l[0], got_l[1], got_l[2]} !== 3'b001) $display("FAIL send_last got %b want 001", {got_l[0], got_l[1], got_l[2]}); else n_pass++;
    end
    tick();
    n_checks++; if (busy !== 1'b0) $display("FAIL send_idle got %b want 0", busy); else n_pass++;
  endtask

  task automatic test_recv(input logic [31:0] payload, input bit exp_ok, input string nm);
    bit tmo, t1, t2, t3;
    begin_txn(1'b1, 8'hFF, 8'hFF, 32'hFFFFFFFF, LW'(1));
    feed(32'h08007377, t1);
    feed(32'h00010001, t2);
    feed(payload, t3);
    n_checks++; if (t1 | t2 | t3) $display("FAIL %s_feed timeout got 1 want 0", nm); else n_pass++;
    collect(tmo);
    n_checks++; if (tmo) $display("FAIL %s_done timeout got 1 want 0", nm); else n_pass++;
    n_checks++; if (checksum_ok !== exp_ok) $display("FAIL %s_ok got %b want %b", nm, checksum_ok, exp_ok); else n_pass++;
    n_checks++; if (typeoficmpout !== 8'd8 || codeout !== 8'd0) $display("FAIL %s_typecode got %h%h want 0800", nm, typeoficmpout, codeout); else n_pass++;
    n_checks++; if (restofheaderout !== 32'h00010001) $display("FAIL %s_rest got %h want 00010001", nm, restofheaderout); else n_pass++;
    n_checks++; if (got_w.size() !== 1) $display("FAIL %s_count got %0d want 1", nm, got_w.size()); else n_pass++;
    if (got_w.size() == 1) begin
      n_checks++; if (got_w[0] !== payload || got_l[0] !== 1'b1) $display("FAIL %s_payload got %h/%b want %h/1", nm, got_w[0], got_l[0], payload); else n_pass++;
    end
    tick();
  endtask

  task automatic test_hold();
    bit tmo;
    begin_txn(1'b0, ICMP_ECHO_REPLY, 8'd3, 32'hDEADBEEF, LW'(0));
    collect(tmo);
    n_checks++; if (tmo) $display("FAIL hold_done timeout got 1 want 0"); else n_pass++;
    n_checks++; if (checksum_ok !== 1'b1 || restofheaderout !== 32'h00010001 || typeoficmpout !== 8'd8)
      $display("FAIL hold_results got %b/%h/%h want 1/00010001/08", checksum_ok, restofheaderout, typeoficmpout); else n_pass++;
    tick();
  endtask

  task automatic test_len0_stall();
    logic [31:0] held;
    bit stalled;
    got_w.delete(); got_l.delete(); got_done = 0; stalled = 1'b0; held = '0;
    begin_txn(1'b0, 8'd0, 8'd0, 32'h12345678, LW'(0));
    n_checks++; if (inputready !== 1'b0) $display("FAIL len0_ready got %b want 0", inputready); else n_pass++;
    for (int c = 0; c < 40; c++) begin
      outputready = c[0];
      if (done) begin
        got_done++;
        break;
      end
      if (outputvalid) begin
        if (stalled) begin
          n_checks++; if (outputmessage !== held) $display("FAIL stall_hold got %h want %h", outputmessage, held); else n_pass++;
        end
        if (outputready) begin
          got_w.push_back(outputmessage);
          got_l.push_back(outputlast);
          stalled = 1'b0;
        end else begin
          held = outputmessage;
          stalled = 1'b1;
        end
      end
      tick();
    end
    outputready = 1'b1;
    n_checks++; if (got_done !== 1) $display("FAIL stall_done got %0d want 1", got_done); else n_pass++;
    n_checks++; if (got_w.size() !== 2) $display("FAIL stall_count got %0d want 2", got_w.size()); else n_pass++;
    if (got_w.size() == 2) begin
      n_checks++; if (got_w[0] !== 32'h00009753 || got_w[1] !== 32'h12345678)
        $display("FAIL stall_words got %h %h want 00009753 12345678", got_w[0], got_w[1]); else n_pass++;
      n_checks++; if ({got_l[0], got_l[1]} !== 2'b01) $display("FAIL stall_last got %b want 01", {got_l[0], got_l[1]}); else n_pass++;
    end
    tick();
  endtask

  task automatic test_saturate_reset();
    int n_acc;
    bit seen;
    n_acc = 0; seen = 1'b0;
    begin_txn(1'b0, 8'd8, 8'd0, 32'h0, LW'(MW + 5));
    inputvalid = 1'b1;
    inputdata  = 32'hA0000000;
    for (int c = 0; c < 60; c++) begin
      if (inputready) begin
        tick();
        n_acc++;
        inputdata = 32'hA0000000 + 32'(n_acc);
      end else if (n_acc > 0) begin
        break;
      end else begin
        tick();
      end
    end
    inputvalid = 1'b0;
    n_checks++; if (n_acc !== MW) $display("FAIL sat_accepted got %0d want %0d", n_acc, MW); else n_pass++;
    outputready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (outputvalid) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    n_checks++; if (!seen) $display("FAIL sat_emit timeout got 0 want 1"); else n_pass++;
    tick(); tick();
    n_checks++; if (outputmessage !== 32'hA0000000) $display("FAIL sat_payload0 got %h want a0000000", outputmessage); else n_pass++;
    hardreset = 1'b1;
    tick();
    n_checks++; if ({inputready, outputvalid, outputlast, done, busy, checksum_ok} !== 6'b0)
      $display("FAIL abort_ctrl got %b want 000000", {inputready, outputvalid, outputlast, done, busy, checksum_ok}); else n_pass++;
    n_checks++; if ({typeoficmpout, codeout, restofheaderout, outputmessage} !== 80'h0)
      $display("FAIL abort_data got %h want 0", {typeoficmpout, codeout, restofheaderout, outputmessage}); else n_pass++;
`ifdef ICMP_STATS_EN
    n_checks++; if ({tx_count, rx_count, bad_count} !== 48'h0)
      $display("FAIL abort_stats got %h want 0", {tx_count, rx_count, bad_count}); else n_pass++;
`endif
    hardreset = 1'b0;
    tick();
  endtask

  initial begin
    hardreset = 1'b1; start = 1'b0; mode = 1'b0; typeoficmpin = '0; codein = '0;
    restofheaderin = '0; payload_len = '0; inputdata = '0; inputvalid = 1'b0; outputready = 1'b1;
    tick();
    test_reset();
    test_send();
    test_recv(32'h41424344, 1'b1, "rx_good");
    test_hold();
    test_recv(32'h41424345, 1'b0, "rx_bad");
`ifdef ICMP_STATS_EN
    n_checks++; if ({tx_count, rx_count, bad_count} !== {16'd2, 16'd2, 16'd1})
      $display("FAIL stats got %h want 000200020001", {tx_count, rx_count, bad_count}); else n_pass++;
`endif
    test_len0_stall();
    test_saturate_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired got running want finished");
    $fatal(1);
  end

endmodule

// File: doc/icmp_codec.md
ICMP_CODEC -- requirements
Module: icmp_codec

Interface
REQ-001 Parameter MAX_WORDS, 16, payload buffer depth in 32-bit words (1..256).
REQ-002 Parameter LEN_W, $clog2(MAX_WORDS+1), width of payload_len.
REQ-003 clock  in  1  sole clock; all logic on rising edge.
REQ-004 hardreset  in  1  reset, synchronous, active-high.
REQ-005 start  in  1  begin transaction (sampled in IDLE only).
REQ-006 mode  in  1  0=send (build message), 1=receive (parse and check).
REQ-007 typeoficmpin, codein  in  8 each  send-mode type and code.
REQ-008 restofheaderin  in  32  send-mode rest-of-header word.
REQ-009 payload_len  in  LEN_W  payload words for this transaction (0..MAX_WORDS).
REQ-010 inputdata  in  32  inbound word; inputvalid in 1; inputready out 1.
REQ-011 outputmessage  out  32  outbound word; outputvalid out 1; outputready in 1; outputlast out 1.
REQ-012 typeoficmpout, codeout  out  8 each; restofheaderout  out  32  receive-mode parsed fields.
REQ-013 checksum_ok  out  1  receive-mode checksum verdict; done  out  1  one-cycle completion pulse; busy  out  1  high when not IDLE.

Function
REQ-014 States SHALL be IDLE, LOAD, FOLD, EMIT, DONE; start in IDLE SHALL capture mode, payload_len, type/code/rest-of-header and enter LOAD.
REQ-015 payload_len > MAX_WORDS SHALL saturate to MAX_WORDS; start outside IDLE SHALL be ignored.
REQ-016 Input word accepted when inputvalid && inputready; inputready SHALL be high only in LOAD.
REQ-017 Send LOAD accepts payload_len words into buffer; receive LOAD accepts 2+payload_len words (header, rest-of-header, payload).
REQ-018 Checksum SHALL be 16-bit one's-complement sum with end-around carry; each accepted word adds both 16-bit halves in the accept cycle.
REQ-019 Send accumulator SHALL start at {type,code} + both restofheaderin halves; payload_len=0 SHALL go IDLE->LOAD->FOLD with no words accepted.
REQ-020 FOLD (one cycle after last accept) SHALL register checksum=~sum (send) or checksum_ok=(sum==16'hFFFF) plus typeoficmpout/codeout/restofheaderout (receive).
REQ-021 Send EMIT SHALL output {type,code,checksum}, restofheader, then payload words in order; total 2+payload_len words.
REQ-022 Receive EMIT SHALL output payload words only; payload_len=0 SHALL skip EMIT to DONE.
REQ-023 outputvalid high only in EMIT; word advances on outputvalid && outputready; outputmessage SHALL hold stable while stalled; outputlast high with final word.
REQ-024 First outputvalid SHALL be asserted in the cycle after FOLD.
REQ-025 DONE SHALL last one cycle with done=1, then IDLE; outputmessage SHALL be 0 outside EMIT.
REQ-026 Receive result outputs SHALL hold until next receive FOLD.

Reset
REQ-027 hardreset SHALL force IDLE from any state, aborting mid-transaction, discarding buffer contents and accumulator.
REQ-028 All outputs SHALL reset to 0 (inputready, outputvalid, outputlast, done, busy, checksum_ok, parsed fields, outputmessage).

Configuration
REQ-029 Macro ICMP_STATS_EN defined: adds outputs tx_count, rx_count, bad_count (16-bit each, saturating at 16'hFFFF, incremented at DONE; bad_count when receive checksum_ok=0; reset to 0).
REQ-030 ICMP_STATS_EN undefined: those ports and counters SHALL be absent; all other behaviour identical.

Structure
REQ-031 Package icmp_pkg SHALL hold state encoding, ICMP_ECHO_REPLY=8'd0, ICMP_ECHO_REQUEST=8'd8, and the one's-complement add function.
REQ-032 Sub-module icmp_csum_acc SHALL implement clear/add-32-bit-word/result accumulator; payload buffer SHALL be inferred RAM/register array in icmp_codec.

Verification
REQ-033 Send type 8 code 0, rest 32'h00010001, len 1, payload 32'h41424344 -> outputs 32'h08007377, 32'h00010001, 32'h41424344 (last), then done.
REQ-034 Receive words 32'h08007377, 32'h00010001, 32'h41424344 -> checksum_ok=1, typeoficmpout=8, restofheaderout=32'h00010001, payload emitted once.
REQ-035 Same receive with payload 32'h41424345 -> checksum_ok=0, payload still emitted, bad_count+1 when ICMP_STATS_EN.
REQ-036 Send len 0, outputready toggling 1/0 -> exactly 2 words, each held stable across stall, outputlast on second.
REQ-037 Send len MAX_WORDS+5 -> MAX_WORDS payload accepted; hardreset asserted during EMIT -> next cycle IDLE, all outputs 0.
